// File: rtl/tsb_pkg.sv
// Shared definitions for the three-state bus sequencer.
//   - tsb_state_e : sequencer FSM state encoding
//   - DEF_*       : default parameter values for the top level
//   - cnt_w_*     : width helpers for indices and counters
package tsb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        TURN  = 2'd2
    } tsb_state_e;

    localparam int DEF_WIDTH     = 16;
    localparam int DEF_CHANNELS  = 4;
    localparam int DEF_MAX_BURST = 4;
    localparam int DEF_TURN_CYC  = 1;

    // Channel index width; at least 1 bit.
    function automatic int idx_w(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

    // Burst counter counts 1..max_burst inclusive.
    function automatic int bcnt_w(input int max_burst);
        return $clog2(max_burst + 1);
    endfunction

    // Turnaround counter holds 0..turn_cyc-1; at least 1 bit.
    function automatic int tcnt_w(input int turn_cyc);
        return (turn_cyc > 1) ? $clog2(turn_cyc) : 1;
    endfunction

endpackage

// File: rtl/tristate_bus_sequencer_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req   : per-channel request
//   ptr   : highest-priority channel this round
//   valid : at least one request present
//   gnt   : one-hot winner
//   idx   : binary index of the winner
// Search order is ptr, ptr+1, ... wrapping modulo CHANNELS.
module rr_arbiter
    import tsb_pkg::*;
#(
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int IDX_W    = idx_w(CHANNELS)
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [IDX_W-1:0]    ptr,
    output logic                valid,
    output logic [CHANNELS-1:0] gnt,
    output logic [IDX_W-1:0]    idx
);

    int c;

    always_comb begin
        valid = 1'b0;
        gnt   = '0;
        idx   = '0;
        c     = 0;
        for (int i = 0; i < CHANNELS; i++) begin
            c = int'(ptr) + i;
            if (c >= CHANNELS) c = c - CHANNELS;
            if (!valid && req[c]) begin
                valid  = 1'b1;
                gnt[c] = 1'b1;
                idx    = IDX_W'(c);
            end
        end
    end

endmodule

// File: rtl/tristate_bus_sequencer.sv
// Multi-channel three-state bus sequencer. CHANNELS sources share one
// WIDTH-bit bus; a round-robin arbiter hands out bounded bursts with
// enforced high-Z turnaround so two drivers are never enabled together.
//   clk, rst_n : clock, async active-low reset
//   req        : per-channel level request
//   din        : channel c data at [c*WIDTH +: WIDTH]
//   gnt        : registered one-hot grant
//   bus        : data_q while bus_oe, else high-Z
//   bus_oe     : registered drive enable
//   owner      : current or last owner index
//   busy       : state is not IDLE
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | bus Z, arbitrating every edge
// DRIVE | owner drives; data resampled each beat, up to MAX_BURST
// TURN  | bus Z for TURN_CYC cycles, arbitrates on the last one
module tristate_bus_sequencer
    import tsb_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int CHANNELS  = DEF_CHANNELS,
    parameter int MAX_BURST = DEF_MAX_BURST,
    parameter int TURN_CYC  = DEF_TURN_CYC
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [CHANNELS-1:0]          req,
    input  logic [CHANNELS*WIDTH-1:0]    din,
    output logic [CHANNELS-1:0]          gnt,
    output tri   [WIDTH-1:0]             bus,
    output logic                         bus_oe,
    output logic [$clog2(CHANNELS)-1:0]  owner,
    output logic                         busy
);

    localparam int IDX_W  = $clog2(CHANNELS);
    localparam int BCNT_W = bcnt_w(MAX_BURST);
    localparam int TCNT_W = tcnt_w(TURN_CYC);

    localparam logic [BCNT_W-1:0] BURST_MAX = BCNT_W'(MAX_BURST);
    localparam logic [TCNT_W-1:0] TURN_LOAD = TCNT_W'(TURN_CYC - 1);
    localparam logic [IDX_W-1:0]  LAST_CH   = IDX_W'(CHANNELS - 1);

    tsb_state_e          state_q, state_d;
    logic [CHANNELS-1:0] gnt_q, gnt_d;
    logic                oe_q, oe_d;
    logic [WIDTH-1:0]    data_q, data_d;
    logic [IDX_W-1:0]    owner_q, owner_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
    logic [TCNT_W-1:0]   tcnt_q, tcnt_d;

    logic                arb_valid;
    logic [CHANNELS-1:0] arb_gnt;
    logic [IDX_W-1:0]    arb_idx;
    logic                do_arb;

    rr_arbiter #(
        .CHANNELS (CHANNELS),
        .IDX_W    (IDX_W)
    ) u_arb (
        .req   (req),
        .ptr   (ptr_q),
        .valid (arb_valid),
        .gnt   (arb_gnt),
        .idx   (arb_idx)
    );

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        oe_d    = oe_q;
        data_d  = data_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        bcnt_d  = bcnt_q;
        tcnt_d  = tcnt_q;
        do_arb  = 1'b0;

        case (state_q)
            IDLE: do_arb = 1'b1;
            DRIVE: begin
                if (req[owner_q] && (bcnt_q < BURST_MAX)) begin
                    data_d = din[owner_q*WIDTH +: WIDTH];
                    bcnt_d = bcnt_q + BCNT_W'(1);
                end else begin
                    // Released owner drops to lowest priority next round.
                    gnt_d   = '0;
                    oe_d    = 1'b0;
                    ptr_d   = (owner_q == LAST_CH) ? '0 : owner_q + IDX_W'(1);
                    tcnt_d  = TURN_LOAD;
                    state_d = TURN;
                end
            end
            TURN: begin
                // Arbitrating on the last Z cycle keeps the gap at exactly TURN_CYC.
                if (tcnt_q != '0) tcnt_d = tcnt_q - TCNT_W'(1);
                else              do_arb = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        if (do_arb) begin
            if (arb_valid) begin
                gnt_d   = arb_gnt;
                oe_d    = 1'b1;
                data_d  = din[arb_idx*WIDTH +: WIDTH];
                owner_d = arb_idx;
                bcnt_d  = BCNT_W'(1);
                state_d = DRIVE;
            end else begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            oe_q    <= 1'b0;
            data_q  <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
            bcnt_q  <= '0;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            oe_q    <= oe_d;
            data_q  <= data_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            bcnt_q  <= bcnt_d;
            tcnt_q  <= tcnt_d;
        end
    end

    assign gnt    = gnt_q;
    assign bus_oe = oe_q;
    assign owner  = owner_q;
    assign busy   = (state_q != IDLE);
    assign bus    = oe_q ? data_q : {WIDTH{1'bz}};

endmodule

// File: tb/tb_tristate_bus_sequencer.sv
// Scoreboard bench: stimulus pushes the expected per-cycle trace, a
// negedge monitor pops and compares. DUT A uses defaults, DUT B uses
// MAX_BURST=2, TURN_CYC=3.
module tb_tristate_bus_sequencer;

    typedef struct packed {
        logic        oe;
        logic [3:0]  gnt;
        logic [1:0]  owner;
        logic        busy;
        logic [15:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_a, rst_b;
    logic [3:0]  req_a, req_b;
    logic [63:0] din_a, din_b;
    logic [3:0]  gnt_a, gnt_b;
    wire  [15:0] bus_a, bus_b;
    logic        oe_a, oe_b, busy_a, busy_b;
    logic [1:0]  owner_a, owner_b;

    exp_t q_a[$];
    exp_t q_b[$];
    int   checks   = 0;
    int   failures = 0;
    int   n_a = 0, n_b = 0;

    always #5 clk = ~clk;

    tristate_bus_sequencer u_dut_a (
        .clk(clk), .rst_n(rst_a), .req(req_a), .din(din_a),
        .gnt(gnt_a), .bus(bus_a), .bus_oe(oe_a), .owner(owner_a), .busy(busy_a)
    );

    tristate_bus_sequencer #(.MAX_BURST(2), .TURN_CYC(3)) u_dut_b (
        .clk(clk), .rst_n(rst_b), .req(req_b), .din(din_b),
        .gnt(gnt_b), .bus(bus_b), .bus_oe(oe_b), .owner(owner_b), .busy(busy_b)
    );

    task automatic mon(input bit sel, input logic oe, input logic [3:0] g,
                       input logic [1:0] ow, input logic bz, input logic [15:0] d);
        exp_t act, e;
        act = '{oe: oe, gnt: g, owner: ow, busy: bz, data: (oe ? d : 16'h0)};
        checks++;
        if (!$onehot0(g) || (oe !== (|g))) begin
            failures++;
            $display("FAIL contention_%s gnt=%b oe=%b required onehot0 and oe==|gnt",
                     sel ? "b" : "a", g, oe);
        end
        if ((sel ? q_b.size() : q_a.size()) > 0) begin
            if (sel) begin e = q_b.pop_front(); n_b++; end
            else     begin e = q_a.pop_front(); n_a++; end
            checks++;
            if (act !== e) begin
                failures++;
                $display("FAIL trace_%s[%0d] actual oe=%b gnt=%b owner=%0d busy=%b data=%h required oe=%b gnt=%b owner=%0d busy=%b data=%h",
                         sel ? "b" : "a", sel ? n_b - 1 : n_a - 1,
                         act.oe, act.gnt, act.owner, act.busy, act.data,
                         e.oe, e.gnt, e.owner, e.busy, e.data);
            end
        end else if (oe) begin
            checks++;
            failures++;
            $display("FAIL idle_drive_%s actual oe=1 data=%h required oe=0", sel ? "b" : "a", d);
        end
    endtask

    always @(negedge clk) begin
        mon(1'b0, oe_a, gnt_a, owner_a, busy_a, bus_a);
        mon(1'b1, oe_b, gnt_b, owner_b, busy_b, bus_b);
    end

    task automatic push(input bit sel, input exp_t e);
        if (sel) q_b.push_back(e);
        else     q_a.push_back(e);
    endtask

    task automatic beat(input bit sel, input int ch, input logic [15:0] d, input int n);
        exp_t e;
        e = '{oe: 1'b1, gnt: 4'(1 << ch), owner: 2'(ch), busy: 1'b1, data: d};
        repeat (n) push(sel, e);
    endtask

    task automatic zc(input bit sel, input int ow, input logic bz, input int n);
        exp_t e;
        e = '{oe: 1'b0, gnt: 4'b0, owner: 2'(ow), busy: bz, data: 16'h0};
        repeat (n) push(sel, e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain(input bit sel, input int budget);
        int n;
        n = 0;
        while (((sel ? q_b.size() : q_a.size()) > 0) && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if ((sel ? q_b.size() : q_a.size()) > 0) begin
            failures++;
            $display("FAIL drain_%s timeout remaining=%0d required 0",
                     sel ? "b" : "a", sel ? q_b.size() : q_a.size());
            if (sel) q_b.delete(); else q_a.delete();
        end
    endtask

    initial begin
        rst_a = 1'b0; rst_b = 1'b0;
        req_a = '0;   req_b = '0;
        din_a = '0;   din_b = '0;
        step(2);
        rst_a = 1'b1; rst_b = 1'b1;

        // 1: idle after reset
        step(1);
        zc(0, 0, 1'b0, 10);
        drain(0, 20);

        // 2: single held requester, burst, one Z cycle, re-grant
        step(1);
        din_a[2*16 +: 16] = 16'hA5A5;
        zc(0, 0, 1'b0, 1);
        beat(0, 2, 16'hA5A5, 4);
        zc(0, 2, 1'b1, 1);
        beat(0, 2, 16'hA5A5, 4);
        zc(0, 2, 1'b1, 1);
        zc(0, 2, 1'b0, 2);
        req_a = 4'b0100;
        step(9);
        req_a = '0;
        drain(0, 30);

        // fresh pointer for the round-robin sweep
        step(1);
        rst_a = 1'b0;
        #2;
        rst_a = 1'b1;

        // 3: all channels requesting, rotation 0,1,2,3,0
        step(1);
        for (int c = 0; c < 4; c++) din_a[c*16 +: 16] = 16'h1000 + 16'(c);
        zc(0, 0, 1'b0, 1);
        for (int k = 0; k < 5; k++) begin
            beat(0, k % 4, 16'h1000 + 16'(k % 4), 4);
            zc(0, k % 4, 1'b1, 1);
        end
        zc(0, 0, 1'b0, 2);
        req_a = 4'b1111;
        step(24);
        req_a = '0;
        drain(0, 50);

        // 4: early drop after two beats, then re-request one cycle later
        step(1);
        zc(0, 0, 1'b0, 1);
        beat(0, 1, 16'h1001, 2);
        zc(0, 1, 1'b1, 1);
        beat(0, 1, 16'h1001, 1);
        zc(0, 1, 1'b1, 1);
        zc(0, 1, 1'b0, 2);
        req_a = 4'b0010;
        step(2);
        req_a = '0;
        step(1);
        req_a = 4'b0010;
        step(1);
        req_a = '0;
        drain(0, 20);

        // 5: async reset mid-burst, then channel 0 wins from ptr=0
        step(1);
        zc(0, 1, 1'b0, 1);
        beat(0, 3, 16'h1003, 2);
        zc(0, 0, 1'b0, 1);
        beat(0, 0, 16'h1000, 4);
        zc(0, 0, 1'b1, 1);
        zc(0, 0, 1'b0, 2);
        req_a = 4'b1000;
        step(2);
        #6;
        rst_a = 1'b0;
        #1;
        checks++;
        if (oe_a !== 1'b0 || gnt_a !== 4'b0) begin
            failures++;
            $display("FAIL async_reset actual oe=%b gnt=%b required oe=0 gnt=0000", oe_a, gnt_a);
        end
        @(posedge clk);
        #7;
        rst_a = 1'b1;
        req_a = 4'b1111;
        step(4);
        req_a = '0;
        drain(0, 20);

        // 6: MAX_BURST=2, TURN_CYC=3, channels 0 and 3 alternate
        step(1);
        din_b[0*16 +: 16] = 16'hB000;
        din_b[3*16 +: 16] = 16'hB003;
        zc(1, 0, 1'b0, 1);
        for (int k = 0; k < 2; k++) begin
            beat(1, 0, 16'hB000, 2);
            zc(1, 0, 1'b1, 3);
            beat(1, 3, 16'hB003, 2);
            zc(1, 3, 1'b1, 3);
        end
        zc(1, 3, 1'b0, 2);
        req_b = 4'b1001;
        step(17);
        req_b = '0;
        drain(1, 40);

        step(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

endmodule
